mem_req_arbiter: RTL and testbench

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/mem_req_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and sizing helper for the memory request arbiter
package mem_arb_pkg;

    // Arbiter FSM states; IDLE is the reset state.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    // Grant pointer width; a single channel still needs a 1-bit pointer.
    function automatic int ptr_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker starting after the last grant
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = ptr_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] last_grant_i,
    output logic [N-1:0]  grant_oh_o,
    output logic [PW-1:0] grant_idx_o
);

    logic [PW-1:0] cand;
    logic          found;

    // Walk upward from last_grant+1 with wrap-around; the first requester wins.
    always_comb begin
        grant_oh_o  = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = '0;
        for (int off = 1; off <= N; off++) begin
            cand = PW'((int'(last_grant_i) + off) % N);
            if (!found && req_i[cand]) begin
                found            = 1'b1;
                grant_oh_o[cand] = 1'b1;
                grant_idx_o      = cand;
            end
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - round-robin cache-line request arbiter in front of AXI read/write masters (optional watchdog: MEM_ARB_TIMEOUT_EN)
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_CH           = 2,
    parameter int BLOCK_WIDTH    = 512,
    parameter int ADDR_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                 clk,
    input  logic                                 i_rst,
    input  logic [N_CH-1:0]                      i_req_valid,
    input  logic [N_CH-1:0]                      i_req_write,
    input  logic [N_CH-1:0][ADDR_WIDTH-1:0]      i_req_addr,
    input  logic [N_CH-1:0][BLOCK_WIDTH-1:0]     i_req_wdata,
    output logic [N_CH-1:0]                      o_req_ready,
    output logic [N_CH-1:0]                      o_resp_valid,
    output logic [BLOCK_WIDTH-1:0]               o_resp_rdata,
    output logic                                 o_resp_err,
    output logic                                 o_start_read_axi,
    output logic                                 o_start_write_axi,
    output logic [ADDR_WIDTH-1:0]                o_addr_axi,
    output logic [BLOCK_WIDTH-1:0]               o_data_write_axi,
    input  logic                                 i_read_last_axi,
    input  logic [BLOCK_WIDTH-1:0]               i_data_read_axi,
    input  logic                                 i_b_resp_axi
);

    localparam int PW = ptr_width(N_CH);

    arb_state_e               state_q, state_d;
    logic [PW-1:0]            last_grant_q, last_grant_d;
    logic [PW-1:0]            grant_idx_q, grant_idx_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [BLOCK_WIDTH-1:0]   wdata_q, wdata_d;
    logic [BLOCK_WIDTH-1:0]   rdata_q, rdata_d;

    logic [N_CH-1:0]          arb_oh;
    logic [PW-1:0]            arb_idx;
    logic                     grant_fire;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     err_q, err_d;
    logic                     timed_out;
`else
    logic [31:0]              unused_timeout_cfg;
    assign unused_timeout_cfg = TIMEOUT_CYCLES;
`endif

    rr_arbiter #(
        .N  (N_CH),
        .PW (PW)
    ) u_rr (
        .req_i        (i_req_valid),
        .last_grant_i (last_grant_q),
        .grant_oh_o   (arb_oh),
        .grant_idx_o  (arb_idx)
    );

    // A grant is only offered in IDLE and never while reset is being applied.
    assign grant_fire = (state_q == IDLE) && (|i_req_valid) && !i_rst;

`ifdef MEM_ARB_TIMEOUT_EN
    assign timed_out  = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign o_resp_err = (state_q == RESP) && err_q;
`else
    assign o_resp_err = 1'b0;
`endif

    assign o_addr_axi       = addr_q;
    assign o_data_write_axi = wdata_q;
    assign o_resp_rdata     = rdata_q;

    // Next-state and output decode; the READ/WRITE state itself carries the request type.
    always_comb begin
        state_d           = state_q;
        last_grant_d      = last_grant_q;
        grant_idx_d       = grant_idx_q;
        addr_d            = addr_q;
        wdata_d           = wdata_q;
        rdata_d           = rdata_q;
        o_req_ready       = '0;
        o_resp_valid      = '0;
        o_start_read_axi  = 1'b0;
        o_start_write_axi = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d             = cnt_q;
        err_d             = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_fire) begin
                    o_req_ready = arb_oh;
                    grant_idx_d = arb_idx;
                    addr_d      = i_req_addr[arb_idx];
                    wdata_d     = i_req_wdata[arb_idx];
                    state_d     = i_req_write[arb_idx] ? WRITE : READ;
`ifdef MEM_ARB_TIMEOUT_EN
                    cnt_d       = '0;
                    err_d       = 1'b0;
`endif
                end
            end
            READ: begin
                o_start_read_axi = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
                cnt_d = cnt_q + CW'(1);
`endif
                if (i_read_last_axi) begin
                    rdata_d = i_data_read_axi;
                    state_d = RESP;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (timed_out) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
`endif
            end
            WRITE: begin
                o_start_write_axi = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
                cnt_d = cnt_q + CW'(1);
`endif
                if (i_b_resp_axi) begin
                    state_d = RESP;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end
`endif
            end
            RESP: begin
                o_resp_valid[grant_idx_q] = 1'b1;
                last_grant_d              = grant_idx_q;
                state_d                   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset hands channel 0 first priority.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            last_grant_q <= PW'(N_CH - 1);
            grant_idx_q  <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_idx_q  <= grant_idx_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
            err_q        <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - directed self-checking bench for mem_req_arbiter (2- and 4-channel instances)
`timescale 1ns/1ps
module tb_mem_req_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vec  = 0;
    int errs = 0;

    // 2-channel instance, default widths
    logic             rst;
    logic [1:0]       req_valid, req_write;
    logic [1:0][63:0] req_addr;
    logic [1:0][511:0] req_wdata;
    logic [1:0]       ready, resp_valid;
    logic [511:0]     rdata, data_w, rd_data;
    logic             err, start_r, start_w, rd_last, bresp;
    logic [63:0]      addr_o;

    mem_req_arbiter #(.N_CH(2), .BLOCK_WIDTH(512), .ADDR_WIDTH(64), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_write(req_write),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata), .o_req_ready(ready),
        .o_resp_valid(resp_valid), .o_resp_rdata(rdata), .o_resp_err(err),
        .o_start_read_axi(start_r), .o_start_write_axi(start_w), .o_addr_axi(addr_o),
        .o_data_write_axi(data_w), .i_read_last_axi(rd_last), .i_data_read_axi(rd_data),
        .i_b_resp_axi(bresp)
    );

    // 4-channel instance, narrow widths
    logic             rst4;
    logic [3:0]       q_valid, q_write, q_ready, q_resp;
    logic [3:0][31:0] q_addr, q_wdata;
    logic [31:0]      q_rdata, q_addr_o, q_wd_o, q_rd;
    logic             q_err, q_sr, q_sw, q_last, q_bresp;

    mem_req_arbiter #(.N_CH(4), .BLOCK_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut4 (
        .clk(clk), .i_rst(rst4), .i_req_valid(q_valid), .i_req_write(q_write),
        .i_req_addr(q_addr), .i_req_wdata(q_wdata), .o_req_ready(q_ready),
        .o_resp_valid(q_resp), .o_resp_rdata(q_rdata), .o_resp_err(q_err),
        .o_start_read_axi(q_sr), .o_start_write_axi(q_sw), .o_addr_axi(q_addr_o),
        .o_data_write_axi(q_wd_o), .i_read_last_axi(q_last), .i_data_read_axi(q_rd),
        .i_b_resp_axi(q_bresp)
    );

    logic [511:0] d0, d1, a5;

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_edge();
        drive_edge();
        req_valid = 2'b11;
        sample();
        vec++; if (ready !== 2'b00) begin errs++; $display("FAIL rst_ready got=%b exp=00", ready); end
        vec++; if (resp_valid !== 2'b00) begin errs++; $display("FAIL rst_resp got=%b exp=00", resp_valid); end
        vec++; if ({start_r, start_w, err} !== 3'b000) begin errs++; $display("FAIL rst_ctrl got=%b exp=000", {start_r, start_w, err}); end
        vec++; if (addr_o !== 64'h0) begin errs++; $display("FAIL rst_addr got=%h exp=0", addr_o); end
        vec++; if (rdata !== 512'h0) begin errs++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
        drive_edge();
        rst = 1'b0;
        req_valid = 2'b00;
    endtask

    task automatic test_rr_reads();
        req_valid = 2'b11; req_write = 2'b00;
        req_addr[0] = 64'h100; req_addr[1] = 64'h200;
        sample();
        vec++; if (ready !== 2'b01) begin errs++; $display("FAIL rr_first_grant got=%b exp=01", ready); end
        drive_edge();
        req_valid = 2'b10;
        sample();
        vec++; if (ready !== 2'b00) begin errs++; $display("FAIL rr_busy_ready got=%b exp=00", ready); end
        vec++; if (start_r !== 1'b1) begin errs++; $display("FAIL rr_start_read got=%b exp=1", start_r); end
        vec++; if (addr_o !== 64'h100) begin errs++; $display("FAIL rr_addr0 got=%h exp=100", addr_o); end
        rd_last = 1'b1; rd_data = d0;
        drive_edge();
        rd_last = 1'b0;
        sample();
        vec++; if (resp_valid !== 2'b01) begin errs++; $display("FAIL rr_resp0 got=%b exp=01", resp_valid); end
        vec++; if (rdata !== d0) begin errs++; $display("FAIL rr_rdata0 got=%h exp=%h", rdata, d0); end
        vec++; if ({start_r, ready} !== 3'b000) begin errs++; $display("FAIL rr_resp_ctrl got=%b exp=000", {start_r, ready}); end
        drive_edge();
        sample();
        vec++; if (ready !== 2'b10) begin errs++; $display("FAIL rr_second_grant got=%b exp=10", ready); end
        drive_edge();
        req_valid = 2'b00;
        sample();
        vec++; if (addr_o !== 64'h200 || start_r !== 1'b1) begin errs++; $display("FAIL rr_addr1 got=%h/%b exp=200/1", addr_o, start_r); end
        rd_last = 1'b1; rd_data = d1;
        drive_edge();
        rd_last = 1'b0;
        sample();
        vec++; if (resp_valid !== 2'b10 || rdata !== d1) begin errs++; $display("FAIL rr_resp1 got=%b/%h exp=10/%h", resp_valid, rdata, d1); end
        drive_edge();
    endtask

    task automatic test_write();
        req_valid = 2'b10; req_write = 2'b10;
        req_addr[1] = 64'h8000_0040; req_wdata[1] = a5;
        sample();
        vec++; if (ready !== 2'b10) begin errs++; $display("FAIL wr_grant got=%b exp=10", ready); end
        drive_edge();
        req_valid = 2'b00; req_write = 2'b00;
        sample();
        vec++; if ({start_w, start_r} !== 2'b10) begin errs++; $display("FAIL wr_start got=%b exp=10", {start_w, start_r}); end
        vec++; if (data_w !== a5) begin errs++; $display("FAIL wr_data got=%h exp=%h", data_w, a5); end
        vec++; if (addr_o !== 64'h8000_0040) begin errs++; $display("FAIL wr_addr got=%h exp=80000040", addr_o); end
        drive_edge();
        sample();
        vec++; if (start_w !== 1'b1 || resp_valid !== 2'b00) begin errs++; $display("FAIL wr_wait got=%b/%b exp=1/00", start_w, resp_valid); end
        bresp = 1'b1;
        drive_edge();
        bresp = 1'b0;
        sample();
        vec++; if (resp_valid !== 2'b10 || start_w !== 1'b0) begin errs++; $display("FAIL wr_resp got=%b/%b exp=10/0", resp_valid, start_w); end
        drive_edge();
        sample();
        vec++; if (resp_valid !== 2'b00) begin errs++; $display("FAIL wr_resp_once got=%b exp=00", resp_valid); end
    endtask

    task automatic test_read_latency();
        drive_edge();
        req_valid = 2'b01; req_addr[0] = 64'h40;
        sample();
        vec++; if (ready !== 2'b01) begin errs++; $display("FAIL lat_grant got=%b exp=01", ready); end
        drive_edge();
        req_valid = 2'b00; rd_last = 1'b1; rd_data = 512'h1234;
        sample();
        vec++; if (start_r !== 1'b1 || resp_valid !== 2'b00) begin errs++; $display("FAIL lat_read got=%b/%b exp=1/00", start_r, resp_valid); end
        drive_edge();
        rd_last = 1'b0;
        sample();
        vec++; if (resp_valid !== 2'b01) begin errs++; $display("FAIL lat_resp got=%b exp=01", resp_valid); end
        vec++; if (rdata !== 512'h1234) begin errs++; $display("FAIL lat_rdata got=%h exp=1234", rdata); end
        drive_edge();
    endtask

    task automatic test_reset_in_read();
        req_valid = 2'b10; req_addr[1] = 64'h300;
        sample();
        vec++; if (ready !== 2'b10) begin errs++; $display("FAIL rir_grant got=%b exp=10", ready); end
        drive_edge();
        req_valid = 2'b00;
        sample();
        vec++; if (start_r !== 1'b1) begin errs++; $display("FAIL rir_read got=%b exp=1", start_r); end
        rst = 1'b1;
        drive_edge();
        rst = 1'b0; req_valid = 2'b11;
        sample();
        vec++; if (start_r !== 1'b0 || resp_valid !== 2'b00) begin errs++; $display("FAIL rir_abort got=%b/%b exp=0/00", start_r, resp_valid); end
        vec++; if (ready !== 2'b01) begin errs++; $display("FAIL rir_ch0_first got=%b exp=01", ready); end
        vec++; if (rdata !== 512'h0 || addr_o !== 64'h0) begin errs++; $display("FAIL rir_cleared got=%h/%h exp=0/0", rdata, addr_o); end
        drive_edge();
        req_valid = 2'b00;
        sample();
        vec++; if (start_r !== 1'b1 || addr_o !== 64'h40) begin errs++; $display("FAIL rir_regrant got=%b/%h exp=1/40", start_r, addr_o); end
        rd_last = 1'b1; rd_data = 512'h55;
        drive_edge();
        rd_last = 1'b0;
        sample();
        vec++; if (resp_valid !== 2'b01) begin errs++; $display("FAIL rir_resp got=%b exp=01", resp_valid); end
        drive_edge();
    endtask

    task automatic test_stray_and_drop();
        rd_last = 1'b1; bresp = 1'b1; rd_data = 512'hDEAD;
        sample();
        vec++; if (ready !== 2'b00) begin errs++; $display("FAIL stray_idle_ready got=%b exp=00", ready); end
        drive_edge();
        sample();
        vec++; if ({start_r, start_w, resp_valid} !== 4'b0000) begin errs++; $display("FAIL stray_idle_ctrl got=%b exp=0000", {start_r, start_w, resp_valid}); end
        vec++; if (rdata !== 512'h55) begin errs++; $display("FAIL stray_idle_rdata got=%h exp=55", rdata); end
        rd_last = 1'b0; bresp = 1'b0;
        drive_edge();
        req_valid = 2'b10; req_write = 2'b00; req_addr[1] = 64'h500;
        sample();
        vec++; if (ready !== 2'b10) begin errs++; $display("FAIL stray_grant got=%b exp=10", ready); end
        drive_edge();
        req_valid = 2'b01; req_write = 2'b01; bresp = 1'b1;
        sample();
        vec++; if (start_r !== 1'b1 || ready !== 2'b00) begin errs++; $display("FAIL stray_read got=%b/%b exp=1/00", start_r, ready); end
        drive_edge();
        bresp = 1'b0; req_valid = 2'b00; req_write = 2'b00;
        sample();
        vec++; if ({start_r, start_w, resp_valid} !== 4'b1000) begin errs++; $display("FAIL stray_bresp_ignored got=%b exp=1000", {start_r, start_w, resp_valid}); end
        rd_last = 1'b1; rd_data = 512'h77;
        drive_edge();
        rd_last = 1'b0;
        sample();
        vec++; if (resp_valid !== 2'b10 || rdata !== 512'h77) begin errs++; $display("FAIL stray_resp got=%b/%h exp=10/77", resp_valid, rdata); end
        for (int i = 0; i < 2; i++) begin
            drive_edge();
            sample();
            vec++; if ({ready, start_r, start_w} !== 4'b0000) begin errs++; $display("FAIL drop_no_effect cyc=%0d got=%b exp=0000", i, {ready, start_r, start_w}); end
        end
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        drive_edge();
        req_valid = 2'b01; req_write = 2'b00;
        sample();
        vec++; if (ready !== 2'b01) begin errs++; $display("FAIL to_grant got=%b exp=01", ready); end
        drive_edge();
        req_valid = 2'b00;
        for (int i = 0; i < 16; i++) begin
            sample();
            vec++; if (start_r !== 1'b1 || resp_valid !== 2'b00) begin errs++; $display("FAIL to_wait cyc=%0d got=%b/%b exp=1/00", i, start_r, resp_valid); end
            drive_edge();
        end
        sample();
        vec++; if (resp_valid !== 2'b01 || err !== 1'b1 || rdata !== 512'h0 || start_r !== 1'b0) begin
            errs++; $display("FAIL to_resp got=%b/%b/%h/%b exp=01/1/0/0", resp_valid, err, rdata, start_r);
        end
        drive_edge();
    endtask
`endif

    task automatic test_n4_order();
        int exp;
        drive_edge();
        rst4 = 1'b0; q_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            exp = k % 4;
            sample();
            vec++; if (q_ready !== 4'(1 << exp)) begin errs++; $display("FAIL n4_grant k=%0d got=%b exp=%b", k, q_ready, 4'(1 << exp)); end
            drive_edge();
            q_bresp = 1'b1;
            sample();
            vec++; if (q_sr !== 1'b1 || q_addr_o !== 32'(exp * 16)) begin errs++; $display("FAIL n4_read k=%0d got=%b/%h exp=1/%h", k, q_sr, q_addr_o, 32'(exp * 16)); end
            drive_edge();
            q_bresp = 1'b0;
            sample();
            vec++; if (q_sr !== 1'b1 || q_resp !== 4'b0000) begin errs++; $display("FAIL n4_stray k=%0d got=%b/%b exp=1/0000", k, q_sr, q_resp); end
            q_last = 1'b1; q_rd = 32'hA000_0000 + 32'(k);
            drive_edge();
            q_last = 1'b0;
            sample();
            vec++; if (q_resp !== 4'(1 << exp) || q_rdata !== 32'hA000_0000 + 32'(k)) begin
                errs++; $display("FAIL n4_resp k=%0d got=%b/%h exp=%b/%h", k, q_resp, q_rdata, 4'(1 << exp), 32'hA000_0000 + 32'(k));
            end
            drive_edge();
        end
        q_valid = 4'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        d0 = {16{32'hC0DE_0000}};
        d1 = {16{32'h0BAD_F00D}};
        a5 = {64{8'hA5}};
        rst = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        rd_last = 1'b0; rd_data = '0; bresp = 1'b0;
        rst4 = 1'b1; q_valid = '0; q_write = '0; q_wdata = '0; q_last = 1'b0; q_rd = '0; q_bresp = 1'b0;
        for (int i = 0; i < 4; i++) q_addr[i] = 32'(i * 16);

        test_reset();
        test_rr_reads();
        test_write();
        test_read_latency();
        test_reset_in_read();
        test_stray_and_drop();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_n4_order();

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
